// File: rtl/qdec_spi_ctrl.sv
// qdec_spi_ctrl: SPI mode-0 slave frame engine that reads out quadrature counters and executes preload/ack commands
module qdec_spi_ctrl (
  input  logic        osc,
  input  logic        rst,
  input  logic        ssel_active,
  input  logic        sck_rise,
  input  logic        sck_fall,
  input  logic        mosi_bit,
  input  logic [31:0] position,
  input  logic [15:0] index_count,
  input  logic [15:0] pulse_count,
  input  logic        index_wrap,
  output logic        miso,
  output logic        load_en,
  output logic [31:0] load_value,
  output logic        irq,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state;
  logic [63:0] tx, rx;
  logic [6:0]  bitcnt;
  logic        frame_end;
  assign frame_end = (state == DONE) && !ssel_active;
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      bitcnt     <= '0;
      miso       <= 1'b0;
      load_en    <= 1'b0;
      load_value <= '0;
      irq        <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load_en   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= index_wrap | (irq & ~frame_end);
      case (state)
        IDLE: if (ssel_active) begin
          state  <= SHIFT;
          busy   <= 1'b1;
          tx     <= {position, index_count, pulse_count};
          rx     <= '0;
          bitcnt <= '0;
          miso   <= position[31];
        end
        SHIFT: if (!ssel_active) begin
          state     <= IDLE;
          busy      <= 1'b0;
          miso      <= 1'b0;
          frame_err <= 1'b1;
        end else if (sck_fall) begin
          // a simultaneous rise is dropped: fall wins
          tx   <= {tx[62:0], 1'b0};
          miso <= tx[62];
        end else if (sck_rise) begin
          rx     <= {rx[62:0], mosi_bit};
          bitcnt <= bitcnt + 7'd1;
          if (bitcnt == 7'd63) begin
            state <= DONE;
            miso  <= 1'b0;
          end
        end
        DONE: if (!ssel_active) begin
          state <= IDLE;
          busy  <= 1'b0;
          if (rx[63:56] == 8'hA5) begin
            load_value <= rx[55:24];
            load_en    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qdec_spi_ctrl.sv
// tb_qdec_spi_ctrl: table-driven and randomized frame-level checks of qdec_spi_ctrl against a transaction model
module tb_qdec_spi_ctrl;
  logic        osc = 0, rst = 1, ssel_active = 0, sck_rise = 0, sck_fall = 0, mosi_bit = 0, index_wrap = 0;
  logic [31:0] position = 0;
  logic [15:0] index_count = 0, pulse_count = 0;
  logic        miso, load_en, irq, frame_err, busy;
  logic [31:0] load_value;

  qdec_spi_ctrl dut (
    .osc(osc), .rst(rst), .ssel_active(ssel_active), .sck_rise(sck_rise), .sck_fall(sck_fall),
    .mosi_bit(mosi_bit), .position(position), .index_count(index_count), .pulse_count(pulse_count),
    .index_wrap(index_wrap), .miso(miso), .load_en(load_en), .load_value(load_value), .irq(irq),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 osc = ~osc;

  int  total = 0, passed = 0;
  bit  inc_pos = 0;
  logic [63:0] o_stream;
  logic        o_le, o_le2, o_err, o_busy, o_idle_busy, o_mdone, o_irq_pre;

  typedef struct {
    logic [31:0] p;
    logic [15:0] ic, pc;
    logic [63:0] m;
    int          nbits;
    bit          wb, wr;
    logic [63:0] es;
    bit          ele;
    logic [31:0] elv;
    bit          eerr, eirq;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge osc);
    #1;
    if (inc_pos) position = position + 1;
  endtask

  task automatic rise_fall(input logic b);
    mosi_bit = b;
    sck_rise = 1;
    tick();
    sck_rise = 0;
    sck_fall = 1;
    tick();
    sck_fall = 0;
  endtask

  task automatic do_frame(input logic [31:0] p, input logic [15:0] ic, input logic [15:0] pc,
                          input logic [63:0] m, input int nbits, input bit wb, input bit wr);
    o_irq_pre = 0;
    if (wb) begin
      index_wrap = 1;
      tick();
      index_wrap = 0;
      o_irq_pre = irq;
    end
    position = p;
    index_count = ic;
    pulse_count = pc;
    ssel_active = 1;
    tick();
    o_busy = busy;
    o_stream = '0;
    for (int k = 0; k < nbits; k++) begin
      o_stream[63-k] = miso;
      rise_fall(m[63-k]);
    end
    o_mdone = (nbits == 64) ? miso : 1'b0;
    ssel_active = 0;
    index_wrap = wr;
    tick();
    index_wrap = 0;
    o_le = load_en;
    o_err = frame_err;
    o_idle_busy = busy;
    tick();
    o_le2 = load_en | frame_err;
  endtask

  task automatic check_frame(input string tag, input int nbits, input bit wb, input logic [63:0] es,
                             input bit ele, input logic [31:0] elv, input bit eerr, input bit eirq);
    if (wb) chk({tag, " irq_set"}, o_irq_pre, 1);
    chk({tag, " busy"}, o_busy, 1);
    if (nbits == 64) begin
      chk({tag, " stream"}, o_stream, es);
      chk({tag, " miso_done"}, o_mdone, 0);
    end
    chk({tag, " load_en"}, o_le, ele);
    chk({tag, " pulse_len"}, o_le2, 0);
    chk({tag, " load_value"}, load_value, elv);
    chk({tag, " frame_err"}, o_err, eerr);
    chk({tag, " irq"}, irq, eirq);
    chk({tag, " idle"}, {o_idle_busy, miso}, 0);
  endtask

  logic [31:0] lv_m;
  bit          irq_m;

  initial begin
    tbl[0] = '{32'h12345678, 16'h0003, 16'h00F0, 64'h0, 64, 0, 0, 64'h12345678_0003_00F0, 0, 32'h0, 0, 0};
    tbl[1] = '{32'h0, 16'h0, 16'h0, 64'hA5CAFEBA_BE000000, 64, 0, 0, 64'h0, 1, 32'hCAFEBABE, 0, 0};
    tbl[2] = '{32'hFFFF0000, 16'h8001, 16'h7FFE, 64'h0, 64, 1, 0, 64'hFFFF0000_8001_7FFE, 0, 32'hCAFEBABE, 0, 0};
    tbl[3] = '{32'h0, 16'h0, 16'h1, 64'h01000000_00000000, 64, 1, 1, 64'h00000000_0000_0001, 0, 32'hCAFEBABE, 0, 1};
    tbl[4] = '{32'h0, 16'h0, 16'h0, 64'hA5123456_78000000, 40, 0, 0, 64'h0, 0, 32'hCAFEBABE, 1, 1};
    tbl[5] = '{32'hA5A5A5A5, 16'h5A5A, 16'hC3C3, 64'h77DEADBE_EF123456, 64, 0, 0, 64'hA5A5A5A5_5A5A_C3C3, 0, 32'hCAFEBABE, 0, 0};

    #1;
    chk("reset_outputs", {miso, load_en, irq, frame_err, busy, load_value}, 0);
    tick();
    tick();
    rst = 0;
    tick();
    chk("post_reset_idle", {miso, busy, irq}, 0);

    foreach (tbl[i]) begin
      do_frame(tbl[i].p, tbl[i].ic, tbl[i].pc, tbl[i].m, tbl[i].nbits, tbl[i].wb, tbl[i].wr);
      check_frame($sformatf("tbl%0d", i), tbl[i].nbits, tbl[i].wb, tbl[i].es, tbl[i].ele, tbl[i].elv, tbl[i].eerr, tbl[i].eirq);
    end

    lv_m = 32'hCAFEBABE;
    irq_m = 0;
    for (int n = 0; n < 25; n++) begin
      logic [31:0] p;
      logic [15:0] ic, pc;
      logic [7:0]  cmd;
      logic [63:0] m;
      int          nb, sel;
      bit          wb, wr, full;
      p = $urandom;
      ic = 16'($urandom);
      pc = 16'($urandom);
      sel = $urandom_range(0, 3);
      cmd = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : (sel == 2) ? 8'hA5 : 8'($urandom);
      m = {cmd, 32'($urandom), 24'($urandom)};
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 63) : 64;
      wb = 1'($urandom);
      wr = 1'($urandom);
      full = (nb == 64);
      if (wb) irq_m = 1;
      if (full && cmd == 8'hA5) lv_m = m[55:24];
      irq_m = full ? wr : (irq_m | wr);
      do_frame(p, ic, pc, m, nb, wb, wr);
      check_frame($sformatf("rnd%0d", n), nb, wb, {p, ic, pc}, full && cmd == 8'hA5, lv_m, !full, irq_m);
    end

    inc_pos = 1;
    do_frame(32'h0000FFFE, 16'h1234, 16'h5678, 64'h0, 64, 0, 0);
    inc_pos = 0;
    chk("snapshot_stable", o_stream, 64'h0000FFFE_1234_5678);

    index_wrap = 1;
    tick();
    index_wrap = 0;
    do_frame(32'h0, 16'h0, 16'h0, 64'hA5000000_01000000, 64, 0, 0);
    chk("preload_small", load_value, 32'h00000001);
    chk("irq_after_wrap_frame", irq, 0);
    index_wrap = 1;
    tick();
    index_wrap = 0;
    position = 32'h4000_0000;
    ssel_active = 1;
    tick();
    sck_rise = 1;
    sck_fall = 1;
    tick();
    sck_rise = 0;
    sck_fall = 0;
    chk("both_edges_shift", miso, 1);
    for (int k = 0; k < 63; k++) begin
      sck_rise = 1;
      tick();
      sck_rise = 0;
      tick();
    end
    chk("both_edges_no_count", {busy, miso}, 2'b11);
    sck_rise = 1;
    tick();
    sck_rise = 0;
    chk("both_edges_done", {busy, miso}, 2'b10);
    ssel_active = 0;
    tick();
    tick();
    chk("both_edges_end", {busy, frame_err, irq}, 0);

    index_wrap = 1;
    tick();
    index_wrap = 0;
    position = 32'h89ABCDEF;
    ssel_active = 1;
    tick();
    for (int k = 0; k < 20; k++) rise_fall(1'b1);
    rst = 1;
    #1;
    chk("reset_midframe", {miso, load_en, irq, frame_err, busy, load_value}, 0);
    ssel_active = 0;
    tick();
    tick();
    rst = 0;
    tick();
    chk("reset_no_err", {frame_err, busy, load_en}, 0);
    do_frame(32'hDEADBEEF, 16'h0102, 16'h0304, 64'h0, 64, 0, 0);
    check_frame("after_reset", 64, 0, 64'hDEADBEEF_0102_0304, 0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
